maxmin_window_sched: RTL

Window scheduler that shares one running max/min tracker between two sample requesters. A requester is granted the tracker for a window of `win_len` samples. The scheduler clears the tracker, streams the granted source's samples into it, then presents the window's max, min, source ID and sample count on a result handshake. It sits between the sample producers and the downstream consumer of max/min statistics.

---
 rtl/maxmin_pkg.sv | 25 ++
 rtl/maxmin_track.sv | 40 ++++
 rtl/maxmin_window_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/maxmin_pkg.sv
// maxmin_pkg: shared types and defaults for the max/min window scheduler.
//   state_t  - scheduler FSM states
//   src_t    - requester index (two sources)
//   rr_pick  - round-robin choice between the two requesters
package maxmin_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int MAX_WIN_DEF = 256;
  localparam int NUM_SRC     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic src_t;

  // The favoured source wins if it is asking; otherwise the other one does.
  // Only meaningful when at least one request bit is set.
  function automatic src_t rr_pick(input logic [NUM_SRC-1:0] req, input src_t ptr);
    return req[ptr] ? ptr : src_t'(~ptr);
  endfunction

endpackage

// File: rtl/maxmin_track.sv
// maxmin_track: running unsigned max/min over a stream of samples.
//   clk, rst  - clock, async active-low reset
//   clr       - start a new window (zeroes max/min, arms first-sample load)
//   en        - accept sample d
//   d         - sample
//   max, min  - registered running extremes
module maxmin_track
  import maxmin_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] min
);

  logic first;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first <= 1'b1;
      max   <= '0;
      min   <= '0;
    end else if (clr) begin
      first <= 1'b1;
      max   <= '0;
      min   <= '0;
    end else if (en) begin
      first <= 1'b0;
      // First sample seeds both; strict compares keep the held value on ties.
      if (first || (d > max)) max <= d;
      if (first || (d < min)) min <= d;
    end
  end

endmodule

// File: rtl/maxmin_window_sched.sv
// maxmin_window_sched: grants a shared max/min tracker to one of two sample
// sources for a window of win_len samples, then presents the result.
//   clk, rst          - clock, async active-low reset
//   req[1:0]          - per-source window request (level)
//   win_len           - window length, sampled at grant (legal 1..MAX_WIN)
//   s_valid/s_ready   - per-source sample handshake; s_data0/s_data1 data
//   grant             - one-hot window owner, 0 when idle
//   busy              - window in progress or result pending
//   m_valid/m_ready   - result handshake
//   m_max, m_min      - window extremes (unsigned)
//   m_src, m_count    - owning source, window length
module maxmin_window_sched
  import maxmin_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MAX_WIN = MAX_WIN_DEF,
  parameter int CW      = $clog2(MAX_WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [CW-1:0]    win_len,
  input  logic [1:0]       s_valid,
  input  logic [WIDTH-1:0] s_data0,
  input  logic [WIDTH-1:0] s_data1,
  output logic [1:0]       s_ready,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_max,
  output logic [WIDTH-1:0] m_min,
  output logic             m_src,
  output logic [CW-1:0]    m_count
);

  state_t        state, state_nxt;
  src_t          ptr;
  src_t          pick;
  logic [CW-1:0] cnt;
  logic          win_ok, start, beat, last, hs;
  logic [WIDTH-1:0] d_sel;

  assign win_ok = (win_len != '0) && (win_len <= CW'(MAX_WIN));
  assign pick   = rr_pick(req, ptr);
  assign start  = (state == IDLE) && (|req) && win_ok;

  // Ready is decoded from registered state and owner so it drops the cycle
  // after the final beat without an extra flop.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_rdy
    assign s_ready[i] = (state == RUN) && grant[i];
  end

  assign beat = |(s_valid & s_ready);
  // m_count doubles as the latched window length.
  assign last = beat && ((cnt + CW'(1)) == m_count);
  assign hs   = (state == DONE) && m_ready;

  // m_src holds the owner from grant onward, so it steers the sample mux.
  assign d_sel = m_src ? s_data1 : s_data0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    if (hs)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant   <= '0;
      busy    <= 1'b0;
      m_valid <= 1'b0;
      m_src   <= 1'b0;
      m_count <= '0;
      cnt     <= '0;
      ptr     <= 1'b0;
    end else begin
      busy    <= (state_nxt != IDLE);
      m_valid <= (state_nxt == DONE);
      if (start) begin
        grant   <= 2'b01 << pick;
        m_src   <= pick;
        m_count <= win_len;
        cnt     <= '0;
      end else if (beat) begin
        cnt <= cnt + CW'(1);
      end
      if (hs) begin
        grant <= '0;
        // Favour whoever was not just served.
        ptr   <= ~m_src;
      end
    end
  end

  // Tracker registers are only written in RUN, so they double as the
  // result registers and hold steady through DONE.
  maxmin_track #(.WIDTH(WIDTH)) u_track (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .en  (beat),
    .d   (d_sel),
    .max (m_max),
    .min (m_min)
  );

endmodule
